// File: rtl/mips_pkg.sv
// Shared miniMIPS definitions: datapath widths, ALU op encoding, opcode/funct
// constants and the decoded-control bundle produced by alu_control.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_SUB = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_sel_e;

    // b_sel: 0 = rt operand, 1 = extended immediate; zext picks zero-extension.
    typedef struct packed {
        alu_op_e   alu_op;
        logic      b_sel;
        logic      zext;
        dest_sel_e dest_sel;
        logic      is_branch;
        logic      illegal;
    } alu_ctrl_t;

endpackage

// File: rtl/id_ex_alu_stage_if.sv
// Decode-side and ALU-side signal bundle of the ID/EX stage.
// Forwarding signals exist only when ID_EX_FWD_EN is defined.
interface id_ex_alu_stage_if;
    import mips_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OPC_W-1:0]    opcode;
    logic [FUNCT_W-1:0]  funct;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [REG_AW-1:0]   rs_addr;
    logic [REG_AW-1:0]   rt_addr;
    logic [REG_AW-1:0]   rd_addr;
    logic [IMM_W-1:0]    imm16;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [REG_AW-1:0]   dest_addr;
    logic                is_branch;
    logic                illegal;
`ifdef ID_EX_FWD_EN
    logic                fwd_valid;
    logic [REG_AW-1:0]   fwd_addr;
    logic [DATA_W-1:0]   fwd_data;
`endif

    modport slave (
`ifdef ID_EX_FWD_EN
        input  fwd_valid, fwd_addr, fwd_data,
`endif
        input  in_valid, opcode, funct, rs_data, rt_data, rs_addr, rt_addr,
               rd_addr, imm16, flush, out_ready,
        output in_ready, out_valid, alu_op, alu_a, alu_b, dest_addr,
               is_branch, illegal
    );

    modport master (
`ifdef ID_EX_FWD_EN
        output fwd_valid, fwd_addr, fwd_data,
`endif
        output in_valid, opcode, funct, rs_data, rt_data, rs_addr, rt_addr,
               rd_addr, imm16, flush, out_ready,
        input  in_ready, out_valid, alu_op, alu_a, alu_b, dest_addr,
               is_branch, illegal
    );

endinterface

// File: rtl/id_ex_alu_stage_alu_control.sv
// Combinational opcode/funct decoder producing ALU op and operand/dest selects;
// shared with the single-cycle datapath.
module alu_control
    import mips_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    output alu_ctrl_t          ctrl
);

    always_comb begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.b_sel     = 1'b0;
        ctrl.zext      = 1'b0;
        ctrl.dest_sel  = DEST_NONE;
        ctrl.is_branch = 1'b0;
        ctrl.illegal   = 1'b0;

        case (opcode)
            OPC_RTYPE: begin
                ctrl.dest_sel = DEST_RD;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: begin
                        ctrl.dest_sel = DEST_NONE;
                        ctrl.illegal  = 1'b1;
                    end
                endcase
            end
            OPC_ADDI, OPC_LW: begin
                ctrl.b_sel    = 1'b1;
                ctrl.dest_sel = DEST_RT;
            end
            OPC_SW: ctrl.b_sel = 1'b1;
            OPC_SLTI: begin
                ctrl.alu_op   = ALU_SLT;
                ctrl.b_sel    = 1'b1;
                ctrl.dest_sel = DEST_RT;
            end
            OPC_ANDI: begin
                ctrl.alu_op   = ALU_AND;
                ctrl.b_sel    = 1'b1;
                ctrl.zext     = 1'b1;
                ctrl.dest_sel = DEST_RT;
            end
            OPC_ORI: begin
                ctrl.alu_op   = ALU_OR;
                ctrl.b_sel    = 1'b1;
                ctrl.zext     = 1'b1;
                ctrl.dest_sel = DEST_RT;
            end
            OPC_BEQ: begin
                ctrl.alu_op    = ALU_SUB;
                ctrl.is_branch = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register in front of the ALU: decode, operand select, and a
// one-entry valid/ready register with flush. ID_EX_FWD_EN adds EX forwarding.
module id_ex_alu_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    id_ex_alu_stage_if.slave  io
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e              state_q,     state_d;
    logic [ALU_OP_W-1:0] alu_op_q,    alu_op_d;
    logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
    logic [REG_AW-1:0]   dest_addr_q, dest_addr_d;
    logic                is_branch_q, is_branch_d;
    logic                illegal_q,   illegal_d;

    alu_ctrl_t           ctrl;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic [DATA_W-1:0]   imm_ext;
    logic                in_ready_c;
    logic                load;

    alu_control u_alu_control (
        .opcode (io.opcode),
        .funct  (io.funct),
        .ctrl   (ctrl)
    );

    // Register operands, optionally overridden by the instruction leaving EX.
    always_comb begin
        rs_val = io.rs_data;
        rt_val = io.rt_data;
`ifdef ID_EX_FWD_EN
        if (io.fwd_valid && (io.fwd_addr != '0)) begin
            if (io.fwd_addr == io.rs_addr) rs_val = io.fwd_data;
            if (io.fwd_addr == io.rt_addr) rt_val = io.fwd_data;
        end
`endif
    end

`ifndef ID_EX_FWD_EN
    logic unused_rs_addr;
    assign unused_rs_addr = ^io.rs_addr;
`endif

    assign imm_ext = ctrl.zext ? {(DATA_W-IMM_W)'(0), io.imm16}
                               : {{(DATA_W-IMM_W){io.imm16[IMM_W-1]}}, io.imm16};

    assign in_ready_c = (state_q == ST_EMPTY) || io.out_ready;
    assign load       = io.in_valid && in_ready_c && !io.flush;

    // Flush beats load, load beats drain; data holds unless a load happens.
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        dest_addr_d = dest_addr_q;
        is_branch_d = is_branch_q;
        illegal_d   = illegal_q;

        if (io.flush) begin
            state_d = ST_EMPTY;
        end else if (load) begin
            state_d     = ST_FULL;
            alu_op_d    = ALU_OP_W'(ctrl.alu_op);
            is_branch_d = ctrl.is_branch;
            illegal_d   = ctrl.illegal;
            if (ctrl.illegal) begin
                alu_a_d = '0;
                alu_b_d = '0;
            end else begin
                alu_a_d = rs_val;
                alu_b_d = ctrl.b_sel ? imm_ext : rt_val;
            end
            case (ctrl.dest_sel)
                DEST_RD: dest_addr_d = io.rd_addr;
                DEST_RT: dest_addr_d = io.rt_addr;
                default: dest_addr_d = '0;
            endcase
        end else if (io.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            alu_op_q    <= ALU_OP_W'(ALU_ADD);
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            dest_addr_q <= '0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            dest_addr_q <= dest_addr_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
        end
    end

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = (state_q == ST_FULL);
    assign io.alu_op    = alu_op_q;
    assign io.alu_a     = alu_a_q;
    assign io.alu_b     = alu_b_q;
    assign io.dest_addr = dest_addr_q;
    assign io.is_branch = is_branch_q;
    assign io.illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed + randomized bench for id_ex_alu_stage with an expected-result queue;
// define ID_EX_FWD_EN to also exercise forwarding.
module tb_id_ex_alu_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_alu_stage_if bus ();

    id_ex_alu_stage dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction table.
    function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] rta, input logic [4:0] rda,
                                   input logic [15:0] imm);
        exp_t e;
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0000, imm};
        e.op = 3'b011; e.a = rs; e.b = rt; e.dest = 5'd0; e.br = 1'b0; e.ill = 1'b0;
        case (opc)
            6'h00: begin
                e.dest = rda;
                case (fn)
                    6'h20: e.op = 3'b011;
                    6'h22: e.op = 3'b010;
                    6'h24: e.op = 3'b000;
                    6'h25: e.op = 3'b001;
                    6'h2A: e.op = 3'b100;
                    default: e.ill = 1'b1;
                endcase
            end
            6'h08: begin e.op = 3'b011; e.b = sx; e.dest = rta; end
            6'h0A: begin e.op = 3'b100; e.b = sx; e.dest = rta; end
            6'h23: begin e.op = 3'b011; e.b = sx; e.dest = rta; end
            6'h2B: begin e.op = 3'b011; e.b = sx; end
            6'h0C: begin e.op = 3'b000; e.b = zx; e.dest = rta; end
            6'h0D: begin e.op = 3'b001; e.b = zx; e.dest = rta; end
            6'h04: begin e.op = 3'b010; e.br = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.op = 3'b011; e.a = 32'h0; e.b = 32'h0; e.dest = 5'd0; e.br = 1'b0;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [4:0] rsa, input logic [4:0] rta,
                         input logic [4:0] rda, input logic [15:0] imm);
        bus.in_valid = v;
        bus.opcode   = opc;
        bus.funct    = fn;
        bus.rs_data  = rsd;
        bus.rt_data  = rtd;
        bus.rs_addr  = rsa;
        bus.rt_addr  = rta;
        bus.rd_addr  = rda;
        bus.imm16    = imm;
    endtask

    // One clock: predict accept/consume before the edge, update the scoreboard
    // at the edge, then compare the registered outputs just after it.
    task automatic cycle();
        exp_t e;
        logic expv, acc, cons, fl;
        logic [31:0] rsv, rtv;
        @(negedge clk);
        expv = (q.size() != 0);
        chk("in_ready", 32'(bus.in_ready), 32'(!expv || bus.out_ready));
        fl   = bus.flush;
        acc  = bus.in_valid && (!expv || bus.out_ready) && !fl;
        cons = expv && bus.out_ready;
        rsv  = bus.rs_data;
        rtv  = bus.rt_data;
`ifdef ID_EX_FWD_EN
        if (bus.fwd_valid && bus.fwd_addr != 5'd0) begin
            if (bus.fwd_addr == bus.rs_addr) rsv = bus.fwd_data;
            if (bus.fwd_addr == bus.rt_addr) rtv = bus.fwd_data;
        end
`endif
        e = model(bus.opcode, bus.funct, rsv, rtv, bus.rt_addr, bus.rd_addr, bus.imm16);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("alu_op", 32'(bus.alu_op), 32'(q[0].op));
            chk("alu_a", bus.alu_a, q[0].a);
            chk("alu_b", bus.alu_b, q[0].b);
            chk("dest_addr", 32'(bus.dest_addr), 32'(q[0].dest));
            chk("is_branch", 32'(bus.is_branch), 32'(q[0].br));
            chk("illegal", 32'(bus.illegal), 32'(q[0].ill));
        end
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] fns [6];
        ops = '{6'h00, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 6'h00, 6'h20, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
`ifdef ID_EX_FWD_EN
        bus.fwd_valid = 1'b0; bus.fwd_addr = 5'd0; bus.fwd_data = 32'h0;
`endif
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd3);
        chk("rst_alu_a", bus.alu_a, 32'h0);
        chk("rst_alu_b", bus.alu_b, 32'h0);
        chk("rst_dest", 32'(bus.dest_addr), 32'd0);
        chk("rst_branch", 32'(bus.is_branch), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
        cycle();

        // add rs=5 rt=7 rd=3
        drive(1'b1, 6'h00, 6'h20, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 16'h0);
        cycle();
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_op", 32'(bus.alu_op), 32'd3);
        chk("add_a", bus.alu_a, 32'd5);
        chk("add_b", bus.alu_b, 32'd7);
        chk("add_dest", 32'(bus.dest_addr), 32'd3);

        drive(1'b1, 6'h08, 6'h00, 32'd9, 32'd1, 5'd1, 5'd6, 5'd0, 16'hFFFF);
        cycle();
        chk("addi_b", bus.alu_b, 32'hFFFF_FFFF);
        chk("addi_dest", 32'(bus.dest_addr), 32'd6);

        drive(1'b1, 6'h0C, 6'h00, 32'd9, 32'd1, 5'd1, 5'd7, 5'd0, 16'hFFFF);
        cycle();
        chk("andi_b", bus.alu_b, 32'h0000_FFFF);
        chk("andi_op", 32'(bus.alu_op), 32'd0);

        // Stall with a sub waiting at the input
        bus.out_ready = 1'b0;
        drive(1'b1, 6'h00, 6'h22, 32'd20, 32'd8, 5'd2, 5'd3, 5'd9, 16'h0);
        repeat (3) cycle();
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_b_held", bus.alu_b, 32'h0000_FFFF);
        bus.out_ready = 1'b1;
        cycle();
        chk("post_stall_op", 32'(bus.alu_op), 32'd2);
        chk("post_stall_dest", 32'(bus.dest_addr), 32'd9);

        // Remaining instruction classes
        drive(1'b1, 6'h0A, 6'h00, 32'hFFFF_FFF0, 32'd0, 5'd1, 5'd4, 5'd0, 16'h8000); cycle();
        drive(1'b1, 6'h0D, 6'h00, 32'h1234_0000, 32'd0, 5'd1, 5'd5, 5'd0, 16'h8001); cycle();
        drive(1'b1, 6'h23, 6'h00, 32'h1000, 32'd0, 5'd1, 5'd8, 5'd0, 16'h0010); cycle();
        drive(1'b1, 6'h2B, 6'h00, 32'h1000, 32'd3, 5'd1, 5'd8, 5'd0, 16'hFFFC); cycle();
        chk("sw_dest", 32'(bus.dest_addr), 32'd0);
        drive(1'b1, 6'h04, 6'h00, 32'd4, 32'd4, 5'd1, 5'd2, 5'd0, 16'h0003); cycle();
        chk("beq_branch", 32'(bus.is_branch), 32'd1);
        chk("beq_b", bus.alu_b, 32'd4);
        drive(1'b1, 6'h00, 6'h25, 32'hF0, 32'h0F, 5'd1, 5'd2, 5'd10, 16'h0); cycle();
        drive(1'b1, 6'h00, 6'h2A, 32'd1, 32'd2, 5'd1, 5'd2, 5'd11, 16'h0); cycle();
        drive(1'b1, 6'h00, 6'h21, 32'd1, 32'd2, 5'd1, 5'd2, 5'd12, 16'h0); cycle();
        chk("bad_funct_ill", 32'(bus.illegal), 32'd1);

        // Flush while FULL with a new incoming instruction
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 32'hAA, 32'hBB, 5'd1, 5'd2, 5'd13, 16'h0);
        cycle();
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;
        drive(1'b0, 6'h00, 6'h20, 32'hAA, 32'hBB, 5'd1, 5'd2, 5'd13, 16'h0);
        cycle();
        chk("flush_dropped", 32'(bus.out_valid), 32'd0);

        // Illegal opcode, then async reset during the stall
        drive(1'b1, 6'h3F, 6'h20, 32'h55, 32'h66, 5'd1, 5'd2, 5'd3, 16'h1234);
        cycle();
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        chk("ill_op", 32'(bus.alu_op), 32'd3);
        chk("ill_a", bus.alu_a, 32'h0);
        chk("ill_b", bus.alu_b, 32'h0);
        chk("ill_dest", 32'(bus.dest_addr), 32'd0);
        drive(1'b0, 6'h00, 6'h20, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_ill", 32'(bus.illegal), 32'd0);
        q.delete();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cycle();

`ifdef ID_EX_FWD_EN
        bus.fwd_valid = 1'b1; bus.fwd_addr = 5'd4; bus.fwd_data = 32'h11;
        drive(1'b1, 6'h00, 6'h20, 32'h99, 32'h2, 5'd4, 5'd2, 5'd3, 16'h0);
        cycle();
        chk("fwd_rs_a", bus.alu_a, 32'h11);
        drive(1'b1, 6'h08, 6'h00, 32'h7, 32'h2, 5'd1, 5'd4, 5'd0, 16'h0005);
        cycle();
        chk("fwd_imm_kept", bus.alu_b, 32'h5);
        bus.fwd_addr = 5'd0;
        drive(1'b1, 6'h00, 6'h20, 32'h99, 32'h2, 5'd0, 5'd2, 5'd3, 16'h0);
        cycle();
        chk("fwd_zero_a", bus.alu_a, 32'h99);
        bus.fwd_valid = 1'b0;
`endif

        // Randomized mix of back-pressure, flush and instruction classes
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 9)],
                  fns[$urandom_range(0, 5)], $urandom, $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 9) == 0);
`ifdef ID_EX_FWD_EN
            bus.fwd_valid = 1'($urandom);
            bus.fwd_addr  = 5'($urandom_range(0, 3));
            bus.fwd_data  = $urandom;
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
